// File: rtl/life_engine_pkg.sv
// Shared types and constants for the Game of Life engine.
// Holds the FSM state type and the 16-bit Fibonacci LFSR definition.
package life_engine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned LFSR_W = 16;

    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 16'h0001;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/life_engine_cell.sv
// One cell of the Life grid: B3/S23 rule over eight neighbour bits.
module life_cell (
    input  logic       alive,
    input  logic [7:0] nbrs,
    output logic       next
);

    logic [3:0] count;

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            count = count + {3'b000, nbrs[i]};
        end
    end

    assign next = (count == 4'd3) || (alive && (count == 4'd2));

endmodule

// File: rtl/life_engine.sv
// Game of Life engine: ROWS x COLS grid, single-step, timed run, load and LFSR seeding.
// Row 0 occupies the low COLS bits of grid.
module life_engine
    import life_engine_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int PERIOD = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 step,
    input  logic                 randomize,
    input  logic [15:0]          seed,
    input  logic                 wrap,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] load_data,
    output logic [ROWS*COLS-1:0] grid,
    output logic [15:0]          gen_count,
    output logic                 stable,
    output logic                 busy
);

    localparam int N = ROWS * COLS;

    state_t            state_q, state_d;
    logic [N-1:0]      grid_q, grid_d, next_grid;
    logic [15:0]       gen_q, gen_d;
    logic              stable_q, stable_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              eval;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int RM = (r + ROWS - 1) % ROWS;
            localparam int RP = (r + 1) % ROWS;
            localparam int CM = (c + COLS - 1) % COLS;
            localparam int CP = (c + 1) % COLS;

            logic       ok_u, ok_d, ok_l, ok_r;
            logic [7:0] nb;

            // Border masks: neighbours that fall off the grid count as dead unless wrapping.
            assign ok_u = wrap | (r != 0);
            assign ok_d = wrap | (r != ROWS - 1);
            assign ok_l = wrap | (c != 0);
            assign ok_r = wrap | (c != COLS - 1);

            assign nb[0] = grid_q[RM*COLS + CM] & ok_u & ok_l;
            assign nb[1] = grid_q[RM*COLS + c]  & ok_u;
            assign nb[2] = grid_q[RM*COLS + CP] & ok_u & ok_r;
            assign nb[3] = grid_q[r*COLS + CM]  & ok_l;
            assign nb[4] = grid_q[r*COLS + CP]  & ok_r;
            assign nb[5] = grid_q[RP*COLS + CM] & ok_d & ok_l;
            assign nb[6] = grid_q[RP*COLS + c]  & ok_d;
            assign nb[7] = grid_q[RP*COLS + CP] & ok_d & ok_r;

            life_cell u_cell (
                .alive (grid_q[r*COLS + c]),
                .nbrs  (nb),
                .next  (next_grid[r*COLS + c])
            );
        end
    end

    always_comb begin
        state_d  = state_q;
        grid_d   = grid_q;
        gen_d    = gen_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        eval     = 1'b0;

        if (state_q == SEED) begin
            if (randomize) begin
                lfsr_d   = lfsr_next(lfsr_q);
                grid_d   = {grid_q[N-COLS-1:0], lfsr_q[COLS-1:0]};
                gen_d    = '0;
                stable_d = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end else if (randomize) begin
            state_d  = SEED;
            lfsr_d   = (seed == '0) ? LFSR_ZERO_SUB : seed;
            gen_d    = '0;
            stable_d = 1'b0;
            cnt_d    = '0;
        end else if (load) begin
            state_d  = IDLE;
            grid_d   = load_data;
            gen_d    = '0;
            stable_d = 1'b0;
            cnt_d    = '0;
        end else if (state_q == IDLE) begin
            if (step) begin
                eval = 1'b1;
            end else if (start && !stable_q) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            if (!start) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cnt_q == 8'(PERIOD - 1)) begin
                cnt_d = '0;
                eval  = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        if (eval) begin
            if (next_grid == grid_q) begin
                stable_d = 1'b1;
                state_d  = IDLE;
            end else begin
                grid_d   = next_grid;
                gen_d    = gen_q + 16'd1;
                stable_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grid_q   <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_ZERO_SUB;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            gen_q    <= gen_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign stable    = stable_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_life_engine.sv
// Directed self-checking bench for life_engine on the default 8x8 grid, PERIOD=4.
module tb_life_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, step, randomize, wrap, load;
    logic [15:0] seed;
    logic [63:0] load_data;
    logic [63:0] grid;
    logic [15:0] gen_count;
    logic        stable, busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] BLINK_H  = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V  = 64'h0000_0008_0808_0000;
    localparam logic [63:0] GLIDER   = 64'h0000_0000_0007_0402;
    localparam logic [63:0] EDGE_H   = 64'h0000_0000_0000_001C;
    localparam logic [63:0] EDGE_WR  = 64'h0800_0000_0000_0808;
    localparam logic [63:0] EDGE_DB  = 64'h0000_0000_0000_0808;
    localparam logic [63:0] BLOCK    = 64'h0000_0018_1800_0000;
    localparam logic [63:0] SEED0_G  = 64'h0102_0408_1020_4080;
    localparam logic [63:0] SEED8K_G = 64'h0001_0204_0810_2040;

    life_engine #(.ROWS(8), .COLS(8), .PERIOD(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .step      (step),
        .randomize (randomize),
        .seed      (seed),
        .wrap      (wrap),
        .load      (load),
        .load_data (load_data),
        .grid      (grid),
        .gen_count (gen_count),
        .stable    (stable),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] pat);
        load_data = pat;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic test_reset();
        start = 0; step = 0; randomize = 0; wrap = 0; load = 0;
        seed = '0; load_data = '0;
        reset_n = 1'b0;
        #2;
        n_checks++;
        if (grid !== 64'h0 || gen_count !== 16'h0 || stable !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: grid=%h gen=%h stable=%b busy=%b expected all zero",
                     grid, gen_count, stable, busy);
        end
        #10 reset_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (grid !== 64'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: grid=%h busy=%b expected 0/0", grid, busy);
        end
        // An empty grid is its own successor: stable on first evaluation.
        do_step();
        n_checks++;
        if (stable !== 1'b1 || gen_count !== 16'd0 || grid !== 64'h0) begin
            n_fail++;
            $display("FAIL empty_stable: stable=%b gen=%0d grid=%h expected 1/0/0",
                     stable, gen_count, grid);
        end
    endtask

    task automatic test_blinker();
        wrap = 1'b0;
        do_load(BLINK_H);
        n_checks++;
        if (grid !== BLINK_H || gen_count !== 16'd0 || stable !== 1'b0) begin
            n_fail++;
            $display("FAIL blinker_load: grid=%h gen=%0d stable=%b expected %h/0/0",
                     grid, gen_count, stable, BLINK_H);
        end
        do_step();
        n_checks++;
        if (grid !== BLINK_V || gen_count !== 16'd1) begin
            n_fail++;
            $display("FAIL blinker_step1: grid=%h gen=%0d expected %h/1", grid, gen_count, BLINK_V);
        end
        do_step();
        n_checks++;
        if (grid !== BLINK_H || gen_count !== 16'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL blinker_step2: grid=%h gen=%0d busy=%b expected %h/2/0",
                     grid, gen_count, busy, BLINK_H);
        end
    endtask

    task automatic test_glider_wrap();
        int cyc;
        wrap = 1'b1;
        do_load(GLIDER);
        start = 1'b1;
        cyc = 0;
        while (gen_count != 16'd32 && cyc < 400) begin
            tick();
            cyc++;
        end
        start = 1'b0;
        n_checks++;
        if (cyc !== 129) begin
            n_fail++;
            $display("FAIL glider_timing: cycles=%0d expected 129", cyc);
        end
        tick();
        n_checks++;
        if (grid !== GLIDER || gen_count !== 16'd32 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glider_wrap: grid=%h gen=%0d busy=%b expected %h/32/0",
                     grid, gen_count, busy, GLIDER);
        end
        tick();
        n_checks++;
        if (grid !== GLIDER || gen_count !== 16'd32) begin
            n_fail++;
            $display("FAIL glider_hold: grid=%h gen=%0d expected %h/32", grid, gen_count, GLIDER);
        end
    endtask

    task automatic test_border();
        wrap = 1'b1;
        do_load(EDGE_H);
        do_step();
        n_checks++;
        if (grid !== EDGE_WR || gen_count !== 16'd1) begin
            n_fail++;
            $display("FAIL border_wrap: grid=%h gen=%0d expected %h/1", grid, gen_count, EDGE_WR);
        end
        wrap = 1'b0;
        do_load(EDGE_H);
        do_step();
        n_checks++;
        if (grid !== EDGE_DB || gen_count !== 16'd1) begin
            n_fail++;
            $display("FAIL border_dead: grid=%h gen=%0d expected %h/1", grid, gen_count, EDGE_DB);
        end
    endtask

    task automatic test_still_life();
        wrap = 1'b0;
        do_load(BLOCK);
        start = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (busy !== 1'b1 || stable !== 1'b0) begin
            n_fail++;
            $display("FAIL still_running: busy=%b stable=%b expected 1/0", busy, stable);
        end
        tick();
        n_checks++;
        if (stable !== 1'b1 || gen_count !== 16'd0 || busy !== 1'b0 || grid !== BLOCK) begin
            n_fail++;
            $display("FAIL still_life: stable=%b gen=%0d busy=%b grid=%h expected 1/0/0/%h",
                     stable, gen_count, busy, grid, BLOCK);
        end
        repeat (6) tick();
        n_checks++;
        if (busy !== 1'b0 || stable !== 1'b1) begin
            n_fail++;
            $display("FAIL still_no_rerun: busy=%b stable=%b expected 0/1", busy, stable);
        end
        start = 1'b0;
        do_load(BLOCK);
        n_checks++;
        if (stable !== 1'b0) begin
            n_fail++;
            $display("FAIL still_load_clear: stable=%b expected 0", stable);
        end
    endtask

    task automatic test_seed();
        int bad;
        do_load(BLINK_H);
        seed = 16'h0000;
        randomize = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b1 || grid !== BLINK_H || gen_count !== 16'd0) begin
            n_fail++;
            $display("FAIL seed_entry: busy=%b grid=%h gen=%0d expected 1/%h/0",
                     busy, grid, gen_count, BLINK_H);
        end
        bad = 0;
        repeat (8) begin
            tick();
            if (busy !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL seed_busy: cycles with busy low=%0d expected 0", bad);
        end
        n_checks++;
        if (grid !== SEED0_G || gen_count !== 16'd0 || stable !== 1'b0) begin
            n_fail++;
            $display("FAIL seed_zero: grid=%h gen=%0d stable=%b expected %h/0/0",
                     grid, gen_count, stable, SEED0_G);
        end
        randomize = 1'b0;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || grid !== SEED0_G) begin
            n_fail++;
            $display("FAIL seed_exit: busy=%b grid=%h expected 0/%h", busy, grid, SEED0_G);
        end
        seed = 16'h8000;
        randomize = 1'b1;
        repeat (9) tick();
        randomize = 1'b0;
        tick();
        n_checks++;
        if (grid !== SEED8K_G || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL seed_8000: grid=%h busy=%b expected %h/0", grid, busy, SEED8K_G);
        end
    endtask

    task automatic test_reset_mid_run();
        wrap = 1'b0;
        do_load(BLINK_H);
        start = 1'b1;
        repeat (7) tick();
        n_checks++;
        if (busy !== 1'b1 || gen_count !== 16'd1 || grid !== BLINK_V) begin
            n_fail++;
            $display("FAIL midrun_pre: busy=%b gen=%0d grid=%h expected 1/1/%h",
                     busy, gen_count, grid, BLINK_V);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (grid !== 64'h0 || gen_count !== 16'd0 || busy !== 1'b0 || stable !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: grid=%h gen=%0d busy=%b stable=%b expected all zero",
                     grid, gen_count, busy, stable);
        end
        start = 1'b0;
        #10 reset_n = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (grid !== 64'h0 || gen_count !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_idle: grid=%h gen=%0d busy=%b expected 0/0/0",
                     grid, gen_count, busy);
        end
        start = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_restart: busy=%b expected 1", busy);
        end
        start = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_glider_wrap();
        test_border();
        test_still_life();
        test_seed();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 SHALL have parameter ROWS, default 8: grid height in cells, range 3..16.
REQ-002 SHALL have parameter COLS, default 8: grid width in cells, range 3..16.
REQ-003 SHALL have parameter PERIOD, default 4: clock cycles per generation in RUN, range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: level; run continuously while high.
REQ-007 SHALL have port step, input, 1 bit: single-cycle pulse; advance exactly one generation.
REQ-008 SHALL have port randomize, input, 1 bit: level; seed the grid from the LFSR while high.
REQ-009 SHALL have port seed, input, 16 bits: LFSR start value.
REQ-010 SHALL have port wrap, input, 1 bit: 1 = toroidal edges, 0 = dead border.
REQ-011 SHALL have port load, input, 1 bit: copy load_data into grid.
REQ-012 SHALL have port load_data, input, ROWS*COLS bits: pattern to load.
REQ-013 SHALL have port grid, output, ROWS*COLS bits: cell r,c at bit r*COLS+c; row 0 in the low bits.
REQ-014 SHALL have port gen_count, output, 16 bits: generations computed since the last load or seed.
REQ-015 SHALL have port stable, output, 1 bit: the last evaluated generation equalled the current grid.
REQ-016 SHALL have port busy, output, 1 bit: high in SEED or RUN.

Function
REQ-017 SHALL implement a state machine with states IDLE, SEED and RUN.
REQ-018 SHALL apply input priority randomize > load > step > start in every state.
REQ-019 SHALL compute the next generation combinationally with standard B3/S23 rules over 8 neighbours; neighbour count is 4 bits.
REQ-020 SHALL treat out-of-range neighbours as dead when wrap=0, and take row/column indices modulo ROWS/COLS when wrap=1.
REQ-021 SHALL sample wrap on every evaluation, so a mode change takes effect at the next generation.
REQ-022 SHALL, when load=1 in IDLE or RUN: grid<=load_data, gen_count<=0, stable<=0, enter or stay in IDLE, clear the period counter.
REQ-023 SHALL, on randomize=1 from IDLE or RUN, enter SEED and load the LFSR with seed; a seed of 0 is replaced by 16'h0001.
REQ-024 SHALL, on each SEED cycle after entry: advance the 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shift grid rows up (row r<=row r-1), set row 0<=lfsr[COLS-1:0], gen_count<=0, stable<=0.
REQ-025 SHALL return from SEED to IDLE on the edge where randomize is sampled low; grid holds.
REQ-026 SHALL, on step=1 in IDLE, evaluate one generation at that edge with latency of 1 cycle; step is ignored in SEED and RUN.
REQ-027 SHALL go from IDLE to RUN when start=1 and stable=0; RUN evaluates when the period counter reaches PERIOD-1, then clears it.
REQ-028 SHALL return from RUN to IDLE when start=0 at the next edge; the counter clears and no partial generation is evaluated.
REQ-029 SHALL, on any evaluation with next==grid: leave grid unchanged, hold gen_count, set stable=1, and enter IDLE.
REQ-030 SHALL otherwise, on evaluation: grid<=next, gen_count<=gen_count+1 (wrapping 16'hFFFF->0), stable<=0.
REQ-031 SHALL not re-enter RUN while stable=1, even with start held high; load, seed or step clears the condition.
REQ-032 SHALL treat an all-dead grid as stable on its first evaluation.

Reset
REQ-033 SHALL, while reset_n=0, immediately force: state IDLE, grid 0, gen_count 0, stable 0, busy 0, period counter 0, LFSR 16'h0001.
REQ-034 SHALL abort a SEED or RUN in progress on reset assertion with no further grid update; after release the block waits in IDLE for new inputs.

Structure
REQ-035 SHALL place in the shared package: the state enum type, LFSR width 16, LFSR tap constant, and the zero-seed substitute value 16'h0001.
REQ-036 SHALL provide sub-module life_cell: combinational 8-neighbour input and current state, next-state output; ROWS*COLS instances are generated.

Verification
REQ-037 SHALL verify blinker: load row 3 cols 2..4 on 8x8, then step -> col 3 rows 2..4 alive, gen_count=1; step again -> original pattern, gen_count=2.
REQ-038 SHALL verify glider wrap: wrap=1, load a glider, start for 32 generations -> grid equals the loaded pattern, gen_count=32.
REQ-039 SHALL verify border mode: with a blinker at row 0 cols 2..4, wrap=1 step gives col 3 rows 7,0,1, and wrap=0 step gives col 3 rows 0,1 only.
REQ-040 SHALL verify still life: load a 2x2 block, start=1 -> after PERIOD cycles stable=1, gen_count=0, state IDLE with start still high.
REQ-041 SHALL verify seeding: seed=0, randomize high for 8 cycles -> rows match the successive LFSR states from 16'h0001, gen_count=0, busy=1 during seeding.
REQ-042 SHALL verify reset mid-run: assert reset_n=0 mid-RUN -> outputs are 0 within the same cycle, and no update occurs until start is re-applied after release.
